// File: rtl/clock_domain_exporter_if.sv
// rtl/clock_domain_exporter_if.sv - crossing bus between exporter (req/data) and importer (ack)
interface clock_domain_exporter_if #(
    parameter int pBits = 8
) ();
    logic             req;
    logic [pBits-1:0] data;
    logic             ack;

    // Exporter drives req/data; importer drives ack back.
    modport exp_master (output req, output data);
    modport exp_slave  (input  req, input  data);
    modport imp_master (output ack);
    modport imp_slave  (input  ack);
endinterface

// File: rtl/clock_domain_exporter.sv
// rtl/clock_domain_exporter.sv - source half of a toggle-handshake CDC with a small word FIFO
module clock_domain_exporter #(
    parameter int pBits  = 8,
    parameter int pDepth = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    clock_domain_exporter_if.exp_master   cd_e,
    clock_domain_exporter_if.imp_slave    cd_i,
    input  logic                          stb,
    input  logic [pBits-1:0]              data,
    output logic                          ready,
    output logic [$clog2(pDepth):0]       level
);
    localparam int AW = $clog2(pDepth);
    localparam int LW = AW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [pBits-1:0] mem_q [pDepth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [1:0]       ack_ff_q, ack_ff_d;
    logic [0:0]       state_q, state_d;
    logic             req_q, req_d;
    logic [pBits-1:0] data_q, data_d;
    logic             ack_s;
    logic             full;
    logic             push;
    logic             pop;

    assign ack_s = ack_ff_q[0];
    assign full  = (level_q == LW'(pDepth));
    assign ready = !full;
    assign level = level_q;
    assign push  = stb && ready;
    // A new word leaves only once the importer has acknowledged the previous one.
    assign pop   = (state_q == ST_IDLE) && (level_q != '0) && (ack_s == req_q);

    assign cd_e.req  = req_q;
    assign cd_e.data = data_q;

    always_comb begin
        ack_ff_d = {cd_i.ack, ack_ff_q[1]};
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        state_d  = state_q;
        req_d    = req_q;
        data_d   = data_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    req_d   = !req_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_s == req_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_ff_q <= 2'b00;
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_ff_q <= ack_ff_d;
            state_q  <= state_d;
            req_q    <= req_d;
            data_q   <= data_d;
        end
    end

    // Storage keeps its contents across reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data;
    end
endmodule

// File: tb/tb_clock_domain_exporter.sv
// tb/tb_clock_domain_exporter.sv - scoreboard bench for clock_domain_exporter with an importer model
module tb_clock_domain_exporter;
    localparam int PB = 8;
    localparam int PD = 4;

    logic clk = 1'b0;
    logic clk_d = 1'b0;
    logic rst = 1'b1;
    always #3 clk = ~clk;
    always #7 clk_d = ~clk_d;

    logic          stb = 1'b0;
    logic [PB-1:0] din = '0;
    logic          ready;
    logic [2:0]    level;

    clock_domain_exporter_if #(.pBits(PB)) xb ();

    logic       imp_en = 1'b0;
    logic       ack_hold = 1'b0;
    logic       ack_r;
    logic [1:0] rq_ff;
    assign xb.ack = imp_en ? ack_r : ack_hold;

    clock_domain_exporter #(.pBits(PB), .pDepth(PD)) dut (
        .clk   (clk),
        .rst   (rst),
        .cd_e  (xb),
        .cd_i  (xb),
        .stb   (stb),
        .data  (din),
        .ready (ready),
        .level (level)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue; a word is accepted when fewer than PD are held,
    // and every req toggle must hand over the oldest held word.
    logic [PB-1:0] exp_q[$];
    logic          last_stb = 1'b0;
    logic [PB-1:0] last_din = '0;
    logic          last_req = 1'b0;
    logic [PB-1:0] inflight = '0;
    int            acc_cnt = 0;
    int            pop_cnt = 0;
    int            rx_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_cnt = 0;
                pop_cnt = 0;
                chk("rst_req", 32'(xb.req), 0);
                chk("rst_data", 32'(xb.data), 0);
                chk("rst_level", 32'(level), 0);
                chk("rst_ready", 32'(ready), 1);
                last_stb = 1'b0;
                last_req = 1'b0;
            end else begin
                int  pre;
                bit  acc;
                pre = exp_q.size();
                acc = last_stb && (pre < PD);
                if (xb.req !== last_req) begin
                    pop_cnt++;
                    n_cmp++;
                    if (pre == 0) begin
                        n_fail++;
                        $display("FAIL pop_when_empty: got req toggle required none at %0t", $time);
                    end else begin
                        logic [PB-1:0] w;
                        w = exp_q.pop_front();
                        chk("pop_word", 32'(xb.data), 32'(w));
                        inflight = w;
                    end
                end
                if (acc) begin
                    exp_q.push_back(last_din);
                    acc_cnt++;
                end
                chk("level", 32'(level), 32'(exp_q.size()));
                chk("ready", 32'(ready), 32'(exp_q.size() < PD));
                last_stb = stb;
                last_req = xb.req;
            end
            last_din = din;
        end
    end

    // Importer in the destination clock: 2-FF on req, capture then ack.
    initial begin
        ack_r = 1'b0;
        rq_ff = 2'b00;
        forever begin
            @(posedge clk_d or posedge rst);
            if (rst) begin
                ack_r = 1'b0;
                rq_ff = 2'b00;
                rx_cnt = 0;
            end else if (imp_en) begin
                if (rq_ff[0] != ack_r) begin
                    rx_cnt++;
                    chk("rx_word", 32'(xb.data), 32'(inflight));
                    ack_r = rq_ff[0];
                end
                rq_ff = {xb.req, rq_ff[1]};
            end
        end
    end

    task automatic do_reset(input logic hold_ack);
        stb = 1'b0;
        imp_en = 1'b0;
        ack_hold = hold_ack;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(xb.req), 0);
        chk("async_rst_level", 32'(level), 0);
        chk("async_rst_ready", 32'(ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || xb.req !== xb.ack) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 3000) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d words left required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int cyc;

        // Single word with a live importer
        do_reset(1'b0);
        imp_en = 1'b1;
        stb = 1'b1;
        din = 8'hA5;
        @(posedge clk);
        #1 stb = 1'b0;
        @(posedge clk);
        #1;
        chk("single_req", 32'(xb.req), 1);
        chk("single_data", 32'(xb.data), 32'h A5);
        wait_drain();
        repeat (20) @(posedge clk);
        #1;
        chk("single_no_retoggle", 32'(xb.req), 1);

        // Burst against a held ack: one in flight, PD buffered, last dropped
        do_reset(1'b0);
        for (int i = 1; i <= 6; i++) begin
            stb = 1'b1;
            din = 8'(i);
            @(posedge clk);
            #1;
        end
        stb = 1'b0;
        @(posedge clk);
        #1;
        chk("burst_level", 32'(level), 4);
        chk("burst_ready", 32'(ready), 0);
        chk("burst_req", 32'(xb.req), 1);
        chk("burst_data", 32'(xb.data), 1);
        imp_en = 1'b1;
        wait_drain();
        chk("burst_acc", 32'(acc_cnt), 5);
        chk("burst_pops", 32'(pop_cnt), 5);

        // Stale ack held through reset
        do_reset(1'b1);
        repeat (4) @(posedge clk);
        #1;
        stb = 1'b1;
        din = 8'h3C;
        @(posedge clk);
        #1 stb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stale_req", 32'(xb.req), 0);
        chk("stale_level", 32'(level), 1);
        ack_hold = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("stale_req_edge2", 32'(xb.req), 0);
        @(posedge clk);
        #1;
        chk("stale_req_edge3", 32'(xb.req), 1);
        chk("stale_data", 32'(xb.data), 32'h3C);
        imp_en = 1'b1;
        wait_drain();

        // Push and pop on the same edge at level 2, write pointer wrapping 3 -> 0
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            stb = 1'b1;
            din = 8'(8'h10 + i);
            @(posedge clk);
            #1;
        end
        stb = 1'b0;
        ack_hold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stb = 1'b1;
        din = 8'h13;
        @(posedge clk);
        #1 stb = 1'b0;
        chk("pp1_level", 32'(level), 2);
        chk("pp1_req", 32'(xb.req), 0);
        chk("pp1_data", 32'(xb.data), 32'h11);
        ack_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        stb = 1'b1;
        din = 8'h14;
        @(posedge clk);
        #1 stb = 1'b0;
        chk("pp2_level", 32'(level), 2);
        chk("pp2_req", 32'(xb.req), 1);
        chk("pp2_data", 32'(xb.data), 32'h12);
        imp_en = 1'b1;
        wait_drain();

        // Reset while waiting for an ack
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            stb = 1'b1;
            din = 8'(8'h20 + i);
            @(posedge clk);
            #1;
        end
        stb = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midwait_req", 32'(xb.req), 0);
        chk("midwait_level", 32'(level), 0);
        chk("midwait_ready", 32'(ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        imp_en = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("midwait_quiet_req", 32'(xb.req), 0);
        chk("midwait_quiet_pops", 32'(pop_cnt), 0);

        // Soak: random words and gaps through a live importer
        do_reset(1'b0);
        imp_en = 1'b1;
        sent = 0;
        cyc = 0;
        while (sent < 256 && cyc < 20000) begin
            if (ready && $urandom_range(0, 2) != 0) begin
                stb = 1'b1;
                din = 8'($urandom);
                sent++;
            end else begin
                stb = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        stb = 1'b0;
        wait_drain();
        chk("soak_sent", 32'(sent), 256);
        chk("soak_acc", 32'(acc_cnt), 32'(sent));
        chk("soak_pops", 32'(pop_cnt), 32'(sent));
        chk("soak_rx", 32'(rx_cnt), 32'(sent));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
